ritc_train_aligner: RTL and testbench

// - Sequences RITC bit-alignment training on the SYSCLK side of the datapath, for one RITC (3 channels x 12 bit lanes).
// - Asserts TRAIN_ON, then for every lane sweeps all IDELAY taps and tests the deserialized data against the training pattern.
// - Loads the centre of the widest good-tap window and reports one result per lane.
// - Sits between the GLITCBUS control registers (start/abort, already synchronized) and the datapath IDELAY load port.

---
 rtl/glitc_ritc_pkg.sv | 35 +++
 rtl/ritc_eye_tracker.sv | 65 ++++++
 rtl/ritc_train_aligner.sv | 248 ++++++++++++++++++++++++
 tb/tb_ritc_train_aligner.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitc_ritc_pkg.sv
// Shared widths, state encoding and lane/sample bit mapping for the RITC
// bit-alignment trainer.
package glitc_ritc_pkg;

  localparam int unsigned LaneW       = 6;
  localparam int unsigned TapW        = 5;
  localparam int unsigned EyeW        = 6;
  localparam int unsigned BitsPerCh   = 12;
  localparam int unsigned SampPerLane = 4;
  localparam int unsigned ChW         = SampPerLane * BitsPerCh;
  localparam int unsigned DataW       = 3 * ChW;

  localparam logic [3:0] TrainPatternDefault = 4'hA;

  typedef enum logic [3:0] {
    StIdle,
    StTrainWait,
    StLoad,
    StSettle,
    StCompare,
    StEval,
    StCenter,
    StReport,
    StFinish
  } state_e;

  // Bit of the deserialized word carrying sample samp of lane = ch*12+bit.
  function automatic logic [7:0] lane_bit_idx(input logic [LaneW-1:0] lane,
                                              input int unsigned samp);
    int unsigned l;
    l = 32'(lane);
    return 8'((l / BitsPerCh) * ChW + samp * BitsPerCh + (l % BitsPerCh));
  endfunction

endpackage

// File: rtl/ritc_eye_tracker.sv
// Tracks the current run of good taps for one lane and keeps the widest
// window seen so far (strictly longer replaces, so ties keep the earliest).
module ritc_eye_tracker
  import glitc_ritc_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clr_i,
  input  logic            tap_valid_i,
  input  logic            good_i,
  input  logic [TapW-1:0] tap_i,
  output logic [TapW-1:0] best_start_o,
  output logic [EyeW-1:0] best_len_o
);

  logic [TapW-1:0] run_start_q, run_start_d;
  logic [TapW-1:0] best_start_q, best_start_d;
  logic [EyeW-1:0] run_len_q, run_len_d;
  logic [EyeW-1:0] best_len_q, best_len_d;

  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clr_i) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (tap_valid_i) begin
      if (good_i) begin
        if (run_len_q == '0) begin
          run_start_d = tap_i;
        end
        run_len_d = run_len_q + 1'b1;
        // Growing run overtakes the best as soon as it is strictly longer.
        if (run_len_d > best_len_q) begin
          best_start_d = run_start_d;
          best_len_d   = run_len_d;
        end
      end else begin
        run_len_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/ritc_train_aligner.sv
// RITC bit-alignment training sequencer: sweeps every IDELAY tap of every lane,
// loads the centre of the widest good window and reports one result per lane.
module ritc_train_aligner
  import glitc_ritc_pkg::*;
#(
  parameter int unsigned NLanes       = 36,
  parameter int unsigned NTaps        = 32,
  parameter logic [3:0]  TrainPattern = TrainPatternDefault,
  parameter int unsigned TrainSettle  = 1024,
  parameter int unsigned TapSettle    = 16,
  parameter int unsigned NSamp        = 256,
  parameter int unsigned MinEye       = 4,
  parameter int unsigned DefaultTap   = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DataW-1:0] data_i,
  output logic             train_on_o,
  output logic             dly_load_o,
  output logic [LaneW-1:0] dly_lane_o,
  output logic [TapW-1:0]  dly_tap_o,
  input  logic             dly_ack_i,
  output logic             res_wr_o,
  output logic [LaneW-1:0] res_lane_o,
  output logic [TapW-1:0]  res_tap_o,
  output logic [EyeW-1:0]  res_eye_o,
  output logic             res_ok_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o
);

  localparam logic [15:0]      TrainLast = 16'(TrainSettle - 1);
  localparam logic [15:0]      TapLast   = 16'(TapSettle - 1);
  localparam logic [15:0]      SampLast  = 16'(NSamp - 1);
  localparam logic [LaneW-1:0] LastLane  = LaneW'(NLanes - 1);
  localparam logic [TapW-1:0]  LastTap   = TapW'(NTaps - 1);
  localparam logic [EyeW-1:0]  MinEyeL   = EyeW'(MinEye);
  localparam logic [TapW-1:0]  DefTap    = TapW'(DefaultTap);

  state_e           state_q, state_d;
  logic [LaneW-1:0] lane_q, lane_d;
  logic [TapW-1:0]  tap_q, tap_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             good_q, good_d;
  logic             center_q, center_d;
  logic             abort_q, abort_d;
  logic             fail_q, fail_d;
  logic             res_wr_q, res_wr_d;
  logic [LaneW-1:0] res_lane_q, res_lane_d;
  logic [TapW-1:0]  res_tap_q, res_tap_d;
  logic [EyeW-1:0]  res_eye_q, res_eye_d;
  logic             res_ok_q, res_ok_d;

  logic             trk_clr, trk_valid;
  logic [TapW-1:0]  best_start;
  logic [EyeW-1:0]  best_len;
  logic [TapW-1:0]  centre_tap;
  logic             eye_ok;
  logic [3:0]       samp;

  ritc_eye_tracker u_eye_tracker (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clr_i        (trk_clr),
    .tap_valid_i  (trk_valid),
    .good_i       (good_q),
    .tap_i        (tap_q),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

  always_comb begin
    samp = '0;
    for (int unsigned s = 0; s < SampPerLane; s++) begin
      samp[s[1:0]] = data_i[lane_bit_idx(lane_q, s)];
    end
  end

  // Half-width offset always fits in 5 bits, so the 5-bit sum is the truncated 6-bit sum.
  assign centre_tap = best_start + TapW'((best_len - EyeW'(1)) >> 1);
  assign eye_ok     = (best_len >= MinEyeL);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    tap_d     = tap_q;
    cnt_d     = cnt_q;
    good_d    = good_q;
    center_d  = center_q;
    abort_d   = abort_q;
    fail_d    = fail_q;
    res_wr_d  = 1'b0;
    trk_clr   = 1'b0;
    trk_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d  = StTrainWait;
          lane_d   = '0;
          tap_d    = '0;
          cnt_d    = '0;
          center_d = 1'b0;
          abort_d  = 1'b0;
          fail_d   = 1'b0;
          trk_clr  = 1'b1;
        end
      end
      StTrainWait: begin
        if (cnt_q == TrainLast) begin
          state_d = StLoad;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StLoad: begin
        if (abort_i) begin
          abort_d = 1'b1;
        end
        if (dly_ack_i) begin
          cnt_d    = '0;
          center_d = 1'b0;
          abort_d  = 1'b0;
          if (abort_q || abort_i) begin
            state_d = StIdle;
          end else if (center_q) begin
            state_d = StReport;
          end else begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (cnt_q == TapLast) begin
          state_d = StCompare;
          cnt_d   = '0;
          good_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StCompare: begin
        good_d = good_q & (samp == TrainPattern);
        if (cnt_q == SampLast) begin
          state_d = StEval;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StEval: begin
        trk_valid = 1'b1;
        if (tap_q == LastTap) begin
          state_d = StCenter;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = StLoad;
        end
      end
      StCenter: begin
        tap_d    = eye_ok ? centre_tap : DefTap;
        center_d = 1'b1;
        state_d  = StLoad;
      end
      StReport: begin
        res_wr_d = 1'b1;
        trk_clr  = 1'b1;
        if (lane_q == LastLane) begin
          state_d = StFinish;
        end else begin
          lane_d  = lane_q + 1'b1;
          tap_d   = '0;
          state_d = StLoad;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A pending load always finishes its handshake; everything else stops at once.
    if (abort_i && (state_q != StIdle) && (state_q != StLoad)) begin
      state_d  = StIdle;
      res_wr_d = 1'b0;
    end

    res_lane_d = res_wr_d ? lane_q   : res_lane_q;
    res_tap_d  = res_wr_d ? tap_q    : res_tap_q;
    res_eye_d  = res_wr_d ? best_len : res_eye_q;
    res_ok_d   = res_wr_d ? eye_ok   : res_ok_q;
    if (res_wr_d && !eye_ok) begin
      fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      lane_q     <= '0;
      tap_q      <= '0;
      cnt_q      <= '0;
      good_q     <= 1'b0;
      center_q   <= 1'b0;
      abort_q    <= 1'b0;
      fail_q     <= 1'b0;
      res_wr_q   <= 1'b0;
      res_lane_q <= '0;
      res_tap_q  <= '0;
      res_eye_q  <= '0;
      res_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      tap_q      <= tap_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      center_q   <= center_d;
      abort_q    <= abort_d;
      fail_q     <= fail_d;
      res_wr_q   <= res_wr_d;
      res_lane_q <= res_lane_d;
      res_tap_q  <= res_tap_d;
      res_eye_q  <= res_eye_d;
      res_ok_q   <= res_ok_d;
    end
  end

  assign train_on_o = (state_q != StIdle) && (state_q != StFinish);
  assign dly_load_o = (state_q == StLoad);
  assign dly_lane_o = lane_q;
  assign dly_tap_o  = tap_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StFinish) && !abort_i;
  assign fail_o     = fail_q;
  assign res_wr_o   = res_wr_q;
  assign res_lane_o = res_lane_q;
  assign res_tap_o  = res_tap_q;
  assign res_eye_o  = res_eye_q;
  assign res_ok_o   = res_ok_q;

endmodule

// File: tb/tb_ritc_train_aligner.sv
// Randomized bench for ritc_train_aligner: an IDELAY/data model drives the lanes
// and a window-scan reference model predicts every load and every lane result.
module tb_ritc_train_aligner;
  import glitc_ritc_pkg::*;

  localparam int NL   = 36;
  localparam int NT   = 32;
  localparam int TSet = 16;
  localparam int TS   = 2;
  localparam int NS   = 8;
  localparam int MinE = 4;
  localparam logic [3:0] Pat = 4'hA;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         dly_ack = 1'b0;
  logic [143:0] data = '0;
  logic         train_on_o, dly_load_o, res_wr_o, res_ok_o, busy_o, done_o, fail_o;
  logic [5:0]   dly_lane_o, res_lane_o, res_eye_o;
  logic [4:0]   dly_tap_o, res_tap_o;

  always #5 clk = ~clk;

  ritc_train_aligner #(
    .NLanes      (NL),
    .NTaps       (NT),
    .TrainPattern(Pat),
    .TrainSettle (TSet),
    .TapSettle   (TS),
    .NSamp       (NS),
    .MinEye      (MinE),
    .DefaultTap  (0)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .abort_i   (abort),
    .data_i    (data),
    .train_on_o(train_on_o),
    .dly_load_o(dly_load_o),
    .dly_lane_o(dly_lane_o),
    .dly_tap_o (dly_tap_o),
    .dly_ack_i (dly_ack),
    .res_wr_o  (res_wr_o),
    .res_lane_o(res_lane_o),
    .res_tap_o (res_tap_o),
    .res_eye_o (res_eye_o),
    .res_ok_o  (res_ok_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .fail_o    (fail_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Stimulus maps and reference model results
  logic [31:0] good_map[NL];
  logic [31:0] glitch_map[NL];
  int exp_tap[NL];
  int exp_eye[NL];
  int exp_ok[NL];
  int exp_fail;
  int got_tap[NL];
  int got_eye[NL];
  int got_ok[NL];

  function automatic logic [31:0] rmask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int t = lo; t <= hi; t++) m = m | (32'd1 << t);
    return m;
  endfunction

  function automatic logic [31:0] rand_map();
    logic [31:0] g;
    int n;
    g = '0;
    if ($urandom_range(0, 7) == 0) return '1;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      int lo = $urandom_range(0, 31);
      int len = $urandom_range(1, 12);
      for (int t = lo; t < lo + len && t < NT; t++) g = g | (32'd1 << t);
    end
    return g;
  endfunction

  // Widest run of good taps, earliest on ties; centre loaded only for wide-enough eyes.
  task automatic build_expected();
    exp_fail = 0;
    for (int l = 0; l < NL; l++) begin
      int bs = 0;
      int bl = 0;
      int t = 0;
      while (t < NT) begin
        if (((good_map[l] >> t) & 32'd1) != 0) begin
          int s = t;
          while (t < NT && ((good_map[l] >> t) & 32'd1) != 0) t++;
          if (t - s > bl) begin
            bl = t - s;
            bs = s;
          end
        end else begin
          t++;
        end
      end
      exp_eye[l] = bl;
      exp_ok[l]  = (bl >= MinE) ? 1 : 0;
      exp_tap[l] = (bl >= MinE) ? bs + (bl - 1) / 2 : 0;
      if (bl < MinE) exp_fail = 1;
    end
  endtask

  // IDELAY / data model
  int  cur_lane = 0;
  int  cur_tap = 0;
  int  since = 0;
  int  g_off = 6;
  bit  waiting = 0;
  int  wait_left = 0;
  bit  ack_was_load = 0;
  int  ack_lane = 0;
  int  ack_tap = 0;
  bit  hold_ack = 0;
  bit  long_en = 0;
  bit  spur_en = 0;

  function automatic logic [143:0] make_data();
    logic [143:0] d;
    logic [3:0] sv;
    int base;
    d = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    sv = Pat;
    if (((good_map[cur_lane] >> cur_tap) & 32'd1) == 0) begin
      if (((glitch_map[cur_lane] >> cur_tap) & 32'd1) != 0) begin
        if (since == g_off) sv = sv ^ (4'd1 << $urandom_range(0, 3));
      end else begin
        sv = Pat ^ 4'($urandom_range(1, 15));
      end
    end
    base = (cur_lane / 12) * 48 + (cur_lane % 12);
    for (int s = 0; s < 4; s++) begin
      d = d & ~(144'd1 << (base + s * 12));
      d = d | (144'((sv >> s) & 4'd1) << (base + s * 12));
    end
    return d;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dly_ack && ack_was_load) begin
        cur_lane = ack_lane;
        cur_tap  = ack_tap;
        since    = 1;
        g_off    = $urandom_range(TS + 3, TS + NS - 2);
        waiting  = 0;
      end else begin
        since++;
      end
      dly_ack = 1'b0;
      ack_was_load = 0;
      if (dly_load_o && !waiting && !hold_ack) begin
        waiting = 1;
        if (long_en && (dly_lane_o == 6'd8 || dly_lane_o == 6'd9)) wait_left = 50;
        else wait_left = $urandom_range(0, 3);
      end
      if (waiting && !hold_ack) begin
        if (wait_left == 0) begin
          dly_ack = 1'b1;
          ack_was_load = 1;
          ack_lane = dly_lane_o;
          ack_tap = dly_tap_o;
        end else begin
          wait_left--;
        end
      end else if (spur_en && !dly_load_o && !waiting && $urandom_range(0, 15) == 0) begin
        dly_ack = 1'b1;
      end
      data = make_data();
    end
  end

  // Scoreboard: load sequence, handshake stability, results, done
  int rep_idx = 0;
  int ld_lane = 0;
  int ld_pos = 0;
  int done_cnt = 0;
  int res_cnt = 0;
  bit p_load = 0;
  bit p_ack = 0;
  int p_lane = 0;
  int p_tap = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (p_load && !p_ack) begin
          check("load_hold", dly_load_o, 1);
          check("lane_hold", dly_lane_o, p_lane);
          check("tap_hold", dly_tap_o, p_tap);
        end
        if (p_load && p_ack) check("load_drop", dly_load_o, 0);
        if (dly_load_o && dly_ack) begin
          if (ld_lane < NL) begin
            check("load_lane", dly_lane_o, ld_lane);
            check("load_tap", dly_tap_o, (ld_pos < NT) ? ld_pos : exp_tap[ld_lane]);
          end else begin
            check("load_extra", ld_lane, NL - 1);
          end
          if (ld_pos == NT) begin
            ld_pos = 0;
            ld_lane++;
          end else begin
            ld_pos++;
          end
        end
        if (res_wr_o) begin
          res_cnt++;
          if (rep_idx < NL) begin
            check("res_lane", res_lane_o, rep_idx);
            check("res_tap", res_tap_o, exp_tap[rep_idx]);
            check("res_eye", res_eye_o, exp_eye[rep_idx]);
            check("res_ok", res_ok_o, exp_ok[rep_idx]);
            got_tap[rep_idx] = res_tap_o;
            got_eye[rep_idx] = res_eye_o;
            got_ok[rep_idx]  = res_ok_o;
          end else begin
            check("res_extra", rep_idx, NL - 1);
          end
          rep_idx++;
        end
        if (done_o) begin
          done_cnt++;
          check("done_lanes", rep_idx, NL);
          check("done_fail", fail_o, exp_fail);
          check("done_train_off", train_on_o, 0);
        end
      end
      p_load = dly_load_o;
      p_ack  = dly_ack;
      p_lane = dly_lane_o;
      p_tap  = dly_tap_o;
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1;
    rep_idx = 0;
    ld_lane = 0;
    ld_pos  = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, done_cnt - d0, 1);
    repeat (5) @(negedge clk);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_idle"}, busy_o, 0);
    check({name, "_res_hold"}, res_lane_o, NL - 1);
  endtask

  task automatic sweep1_maps();
    for (int l = 0; l < NL; l++) begin
      good_map[l] = '1;
      glitch_map[l] = $urandom;
    end
    good_map[0] = rmask(10, 20);
    good_map[2] = rmask(3, 5) | rmask(12, 22);
    good_map[3] = rmask(2, 6) | rmask(20, 24);
    good_map[4] = ~(32'd1 << 8);
    glitch_map[4] = 32'd1 << 8;
    good_map[5] = '0;
  endtask

  initial begin
    int n;
    int rc;
    sweep1_maps();
    build_expected();
    repeat (2) @(negedge clk);
    check("rst_train_on", train_on_o, 0);
    check("rst_load", dly_load_o, 0);
    check("rst_lane_tap", {dly_lane_o, dly_tap_o}, 0);
    check("rst_res", {res_wr_o, res_lane_o, res_tap_o, res_eye_o, res_ok_o}, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done_fail", {done_o, fail_o}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Model pins
    check("model_l0_tap", exp_tap[0], 15);
    check("model_l0_eye", exp_eye[0], 11);
    check("model_l2_tap", exp_tap[2], 17);
    check("model_l3_tap", exp_tap[3], 4);
    check("model_l4_tap", exp_tap[4], 20);
    check("model_l4_eye", exp_eye[4], 23);

    // Sweep 1: directed lanes, long ack latency on lanes 8 and 9
    long_en = 1;
    do_start();
    @(negedge clk);
    check("s1_train_on", train_on_o, 1);
    check("s1_busy", busy_o, 1);
    wait_done("s1");
    long_en = 0;
    check("s1_l0_tap", got_tap[0], 15);
    check("s1_l0_eye", got_eye[0], 11);
    check("s1_l0_ok", got_ok[0], 1);
    check("s1_l1_tap", got_tap[1], 15);
    check("s1_l1_eye", got_eye[1], 32);
    check("s1_l2_tap", got_tap[2], 17);
    check("s1_l2_eye", got_eye[2], 11);
    check("s1_l3_tap", got_tap[3], 4);
    check("s1_l4_tap", got_tap[4], 20);
    check("s1_l4_eye", got_eye[4], 23);
    check("s1_l5_tap", got_tap[5], 0);
    check("s1_l5_eye", got_eye[5], 0);
    check("s1_l5_ok", got_ok[5], 0);
    check("s1_l35_tap", got_tap[35], 15);
    check("s1_fail", fail_o, 1);
    check("s1_train_off", train_on_o, 0);

    // Sweep 2: random windows, spurious acks, a start pulse while busy
    for (int l = 0; l < NL; l++) begin
      good_map[l] = rand_map();
      glitch_map[l] = $urandom;
    end
    build_expected();
    spur_en = 1;
    do_start();
    repeat (2000) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("s2");

    // Abort during COMPARE on lane 7
    sweep1_maps();
    build_expected();
    spur_en = 0;
    do_start();
    n = 0;
    while (!(cur_lane == 7 && since == TS + 4) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("a1_reached_lane7", cur_lane, 7);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    rc = res_cnt;
    @(negedge clk);
    check("a1_idle", busy_o, 0);
    check("a1_train_off", train_on_o, 0);
    repeat (30) @(negedge clk);
    check("a1_reported", rep_idx, 7);
    check("a1_no_res", res_cnt - rc, 0);
    check("a1_no_done", done_cnt, 2);
    check("a1_fail_kept", fail_o, 1);

    // Abort during LOAD: handshake completes first, then IDLE
    hold_ack = 1;
    do_start();
    @(negedge clk);
    check("a2_fail_cleared", fail_o, 0);
    n = 0;
    while (!dly_load_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a2_load_seen", dly_load_o, 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (10) @(negedge clk);
    check("a2_still_busy", busy_o, 1);
    check("a2_still_load", dly_load_o, 1);
    hold_ack = 0;
    n = 0;
    while (busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("a2_idle", busy_o, 0);
    check("a2_train_off", train_on_o, 0);
    check("a2_load_done", ld_pos, 1);
    check("a2_no_done", done_cnt, 2);

    // Simultaneous start and abort from IDLE: abort wins
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("sa_stay_idle", busy_o, 0);

    // Final random sweep rescans from lane 0
    for (int l = 0; l < NL; l++) begin
      good_map[l] = rand_map();
      glitch_map[l] = $urandom;
    end
    build_expected();
    spur_en = 1;
    do_start();
    wait_done("s3");
    check("total_done", done_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
